// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 MAR/MDR memory + MMIO device port:
// MMIO register addresses, access direction encoding and the master FSM states.
package lc3_bus_pkg;

  // MMIO register map; the master treats these as ordinary addresses
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  // r_w / req_we encoding
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_MAR   = 3'd1,
    ST_LD_MDR   = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_GATE     = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Word accesses are byte-pair aligned; an odd address is rejected up front
  function automatic logic addr_misaligned(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/lc3_mem_master_if.sv
// Request/response handshake plus device-side strobes and bus of the LC-3
// memory master. The master modport is the CPU-side initiator; the slave
// modport is the view of whoever issues requests and models the device.
interface lc3_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_o;
  logic        bus_oe;
  logic        ld_mar;
  logic        ld_mdr;
  logic        mio_en;
  logic        r_w;
  logic        gate_mdr_en;
  logic [15:0] mdr_in;
  logic        ready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mdr_in, ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_o, bus_oe, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mdr_in, ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_o, bus_oe, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en
  );
endinterface

// File: rtl/lc3_wait_timer.sv
// Loadable saturating down-counter. Reloaded on every ACCESS / WAIT_RDY
// entry; done flags that the loaded interval has fully elapsed.
module lc3_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Count down from the loaded value and stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/lc3_mem_master.sv
// CPU-side initiator for the LC-3 MAR/MDR memory + MMIO port. Latches one
// request, sequences MAR load, MDR load, access, ready wait and MDR gate,
// then returns read data or an error with a one-cycle rsp_valid pulse.
// All outputs are registered and decoded from the next state, so each
// output is a pure function of the state it belongs to.
module lc3_mem_master
  import lc3_bus_pkg::*;
#(
  parameter int ACCESS_CYC  = 1,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_mem_master_if.master  m
);

  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_r, state_nx_s;
  logic             we_r, we_nx_s;
  logic [15:0]      addr_r, addr_nx_s;
  logic [15:0]      wdata_r, wdata_nx_s;
  logic [15:0]      rdata_r, rdata_nx_s;
  logic             err_r, err_nx_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic [CNT_W-1:0] tmr_cnt_s;
  logic             tmr_done_s;
  logic             wait_first_s;

  // decoded next-cycle outputs and their registers
  logic        req_ready_s, rsp_valid_s, bus_oe_s, ld_mar_s, ld_mdr_s;
  logic        mio_en_s, r_w_s, gate_s;
  logic [15:0] bus_o_s;
  logic        req_ready_r, rsp_valid_r, bus_oe_r, ld_mar_r, ld_mdr_r;
  logic        mio_en_r, r_w_r, gate_r;
  logic [15:0] bus_o_r;

  lc3_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .cnt      (tmr_cnt_s),
    .done     (tmr_done_s)
  );

  // The device drops ready one cycle late, so the first WAIT_RDY cycle is ignored
  assign wait_first_s = (tmr_cnt_s == TO_LOAD);

  // Next-state, request latch, response data and timer reload
  always_comb begin
    state_nx_s = state_r;
    we_nx_s    = we_r;
    addr_nx_s  = addr_r;
    wdata_nx_s = wdata_r;
    rdata_nx_s = rdata_r;
    err_nx_s   = err_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (m.req_valid) begin
          we_nx_s    = m.req_we;
          addr_nx_s  = m.req_addr;
          wdata_nx_s = m.req_wdata;
          rdata_nx_s = 16'h0000;
          if (addr_misaligned(m.req_addr)) begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_DONE;
          end else begin
            err_nx_s   = 1'b0;
            state_nx_s = ST_LD_MAR;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LD_MAR: begin
        if (we_r == ACC_WRITE) begin
          state_nx_s = ST_LD_MDR;
        end else begin
          state_nx_s = ST_ACCESS;
          tmr_load_s = 1'b1;
          tmr_val_s  = ACC_LOAD;
        end
      end
      ST_LD_MDR: begin
        state_nx_s = ST_ACCESS;
        tmr_load_s = 1'b1;
        tmr_val_s  = ACC_LOAD;
      end
      ST_ACCESS: begin
        if (tmr_done_s) begin
          state_nx_s = ST_WAIT_RDY;
          tmr_load_s = 1'b1;
          tmr_val_s  = TO_LOAD;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_WAIT_RDY: begin
        if (m.ready && !wait_first_s) begin
          state_nx_s = (we_r == ACC_WRITE) ? ST_DONE : ST_GATE;
        end else if (tmr_done_s) begin
          state_nx_s = ST_DONE;
          err_nx_s   = 1'b1;
          rdata_nx_s = 16'h0000;
        end else begin
          state_nx_s = ST_WAIT_RDY;
        end
      end
      ST_GATE: begin
        rdata_nx_s = m.mdr_in;
        state_nx_s = ST_DONE;
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    bus_oe_s    = 1'b0;
    bus_o_s     = 16'h0000;
    ld_mar_s    = 1'b0;
    ld_mdr_s    = 1'b0;
    mio_en_s    = 1'b0;
    r_w_s       = ACC_READ;
    gate_s      = 1'b0;
    case (state_nx_s)
      ST_IDLE: begin
        req_ready_s = 1'b1;
      end
      ST_LD_MAR: begin
        bus_oe_s = 1'b1;
        bus_o_s  = addr_nx_s;
        ld_mar_s = 1'b1;
      end
      ST_LD_MDR: begin
        bus_oe_s = 1'b1;
        bus_o_s  = wdata_nx_s;
        ld_mdr_s = 1'b1;
      end
      ST_ACCESS: begin
        mio_en_s = 1'b1;
        r_w_s    = we_nx_s;
        ld_mdr_s = (we_nx_s == ACC_READ);
      end
      ST_WAIT_RDY: begin
        mio_en_s = 1'b0;
      end
      ST_GATE: begin
        gate_s = 1'b1;
      end
      ST_DONE: begin
        rsp_valid_s = 1'b1;
      end
      default: begin
        req_ready_s = 1'b0;
      end
    endcase
  end

  // State, request latch, response data and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      addr_r      <= 16'h0000;
      wdata_r     <= 16'h0000;
      rdata_r     <= 16'h0000;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      bus_oe_r    <= 1'b0;
      bus_o_r     <= 16'h0000;
      ld_mar_r    <= 1'b0;
      ld_mdr_r    <= 1'b0;
      mio_en_r    <= 1'b0;
      r_w_r       <= 1'b0;
      gate_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      we_r        <= we_nx_s;
      addr_r      <= addr_nx_s;
      wdata_r     <= wdata_nx_s;
      rdata_r     <= rdata_nx_s;
      err_r       <= err_nx_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      bus_oe_r    <= bus_oe_s;
      bus_o_r     <= bus_o_s;
      ld_mar_r    <= ld_mar_s;
      ld_mdr_r    <= ld_mdr_s;
      mio_en_r    <= mio_en_s;
      r_w_r       <= r_w_s;
      gate_r      <= gate_s;
    end
  end

  assign m.req_ready   = req_ready_r;
  assign m.rsp_valid   = rsp_valid_r;
  assign m.rsp_rdata   = rdata_r;
  assign m.rsp_err     = err_r;
  assign m.bus_o       = bus_o_r;
  assign m.bus_oe      = bus_oe_r;
  assign m.ld_mar      = ld_mar_r;
  assign m.ld_mdr      = ld_mdr_r;
  assign m.mio_en      = mio_en_r;
  assign m.r_w         = r_w_r;
  assign m.gate_mdr_en = gate_r;

endmodule

// File: tb/tb_lc3_mem_master.sv
// Bench for lc3_mem_master: a behavioural MAR/MDR memory + MMIO device,
// a response scoreboard with per-request latency, and a second instance
// with a longer access window.
module tb_lc3_mem_master;
  import lc3_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3_mem_master_if m_if ();
  lc3_mem_master_if m3_if ();

  lc3_mem_master #(.ACCESS_CYC(1), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .clk (clk), .rst_n (rst_n), .m (m_if)
  );

  lc3_mem_master #(.ACCESS_CYC(3), .TIMEOUT_CYC(16), .CNT_W(8)) dut3 (
    .clk (clk), .rst_n (rst_n), .m (m3_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- device model ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] mar_r, mdr_r, ddr_r;
  logic [15:0] kbdr = 16'h0061;
  logic        mio_d_r, rdy_r;
  logic        force_nrdy = 1'b0;

  // Registered device: ready stays high one cycle after the access
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_r   <= 16'h0000;
      mdr_r   <= 16'h0000;
      ddr_r   <= 16'h0000;
      mio_d_r <= 1'b0;
      rdy_r   <= 1'b0;
    end else begin
      if (m_if.ld_mar) mar_r <= m_if.bus_o;
      if (m_if.ld_mdr && m_if.bus_oe) mdr_r <= m_if.bus_o;
      if (m_if.mio_en && m_if.r_w) begin
        if (mar_r == DDR_ADDR) ddr_r <= mdr_r;
        else mem[mar_r] <= mdr_r;
      end
      if (m_if.mio_en && !m_if.r_w && m_if.ld_mdr)
        mdr_r <= (mar_r == KBDR_ADDR) ? kbdr : mem[mar_r];
      mio_d_r <= m_if.mio_en;
      rdy_r   <= (m_if.mio_en | mio_d_r) & ~force_nrdy;
    end
  end

  assign m_if.ready   = rdy_r;
  assign m_if.mdr_in  = mdr_r;
  assign m3_if.ready  = 1'b1;
  assign m3_if.mdr_in = 16'h0000;

  // ---------------- counters ----------------
  int edge_cnt = 0;
  int acc_cnt  = 0;
  int mar_cnt  = 0;
  int mio_cnt  = 0;

  // Edge index plus accept / strobe tallies for the main instance
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst_n && m_if.req_valid && m_if.req_ready) acc_cnt <= acc_cnt + 1;
    if (m_if.ld_mar) mar_cnt <= mar_cnt + 1;
    if (m_if.mio_en) mio_cnt <= mio_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Compare every completion against the oldest expectation; check bus exclusivity
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl", {30'd0, m_if.bus_oe & m_if.gate_mdr_en, m_if.ld_mar & m_if.ld_mdr}, 32'd0);
      if (m_if.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", {16'd0, m_if.rsp_rdata}, {16'd0, e.rdata});
          chk("err", {31'd0, m_if.rsp_err}, {31'd0, e.err});
          chk("lat", edge_cnt + 1 - e.acc, e.lat);
        end
      end
    end
  end

  // Issue one request from a negedge; push its expectation when push=1
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input logic push);
    for (int i = 0; i < 200 && !m_if.req_ready; i++) @(negedge clk);
    chk("rdy_wait", {31'd0, m_if.req_ready}, 32'd1);
    m_if.req_valid = 1'b1;
    m_if.req_we    = we;
    m_if.req_addr  = addr;
    m_if.req_wdata = wdata;
    if (push) sb.push_back('{rdata: exp_rdata, err: exp_err, acc: edge_cnt + 1, lat: exp_lat});
    @(negedge clk);
    m_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
  endtask

  logic [15:0] mem_before;
  int          acc_before, mar_before, mio_before;
  int          a3, n3, lat3;

  initial begin
    m_if.req_valid  = 1'b0;
    m_if.req_we     = 1'b0;
    m_if.req_addr   = 16'h0000;
    m_if.req_wdata  = 16'h0000;
    m3_if.req_valid = 1'b0;
    m3_if.req_we    = 1'b0;
    m3_if.req_addr  = 16'h0000;
    m3_if.req_wdata = 16'h0000;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_strb", {24'd0, m_if.bus_oe, m_if.ld_mar, m_if.ld_mdr, m_if.mio_en,
                     m_if.r_w, m_if.gate_mdr_en, m_if.rsp_valid, m_if.rsp_err}, 32'd0);
    chk("rst_bus", {16'd0, m_if.bus_o}, 32'd0);
    chk("rst_rdata", {16'd0, m_if.rsp_rdata}, 32'd0);
    chk("rst_ready", {31'd0, m_if.req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read back
    do_req(1'b1, 16'h3000, 16'h1234, 16'h0000, 1'b0, 6, 1'b1);
    drain();
    do_req(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 6, 1'b1);
    drain();

    // MMIO: display data write and keyboard data read
    do_req(1'b1, DDR_ADDR, 16'h0041, 16'h0000, 1'b0, 6, 1'b1);
    drain();
    chk("ddr", {16'd0, ddr_r}, 32'h0041);
    do_req(1'b0, KBDR_ADDR, 16'h0000, 16'h0061, 1'b0, 6, 1'b1);
    drain();

    // odd address: immediate error, no bus cycle
    mar_before = mar_cnt;
    mio_before = mio_cnt;
    do_req(1'b0, 16'h3001, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
    drain();
    chk("odd_mar", mar_cnt - mar_before, 32'd0);
    chk("odd_mio", mio_cnt - mio_before, 32'd0);

    // ready timeout, then a normal access
    force_nrdy = 1'b1;
    do_req(1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b1, 19, 1'b1);
    drain();
    force_nrdy = 1'b0;
    do_req(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 6, 1'b1);
    drain();

    // busy: req_valid stays high with changing fields; only the first is taken
    acc_before = acc_cnt;
    do_req(1'b1, 16'h3004, 16'h0055, 16'h0000, 1'b0, 6, 1'b1);
    m_if.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_if.req_addr  = 16'h3006 + 16'(2 * i);
      m_if.req_wdata = 16'h0066 + 16'(i);
      @(negedge clk);
    end
    m_if.req_valid = 1'b0;
    drain();
    chk("busy_acc", acc_cnt - acc_before, 32'd1);
    do_req(1'b0, 16'h3004, 16'h0000, 16'h0055, 1'b0, 6, 1'b1);
    drain();

    // reset while a write is in ACCESS
    mem_before = mem[16'h3002];
    do_req(1'b1, 16'h3002, ~mem_before, 16'h0000, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10 && !m_if.mio_en; i++) @(negedge clk);
    chk("mid_access", {31'd0, m_if.mio_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {25'd0, m_if.bus_oe, m_if.ld_mar, m_if.ld_mdr, m_if.mio_en,
                    m_if.r_w, m_if.gate_mdr_en, m_if.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'd0, m_if.req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    chk("rst_mem", {16'd0, mem[16'h3002]}, {16'd0, mem_before});

    // longer access window on the second instance
    m3_if.req_valid = 1'b1;
    m3_if.req_we    = 1'b1;
    m3_if.req_addr  = 16'h3000;
    m3_if.req_wdata = 16'h0777;
    a3 = edge_cnt + 1;
    @(negedge clk);
    m3_if.req_valid = 1'b0;
    n3   = 0;
    lat3 = 0;
    for (int i = 0; i < 30; i++) begin
      if (m3_if.mio_en) n3++;
      if (m3_if.rsp_valid && lat3 == 0) lat3 = edge_cnt + 1 - a3;
      @(negedge clk);
    end
    chk("acc3_mio", n3, 32'd3);
    chk("acc3_lat", lat3, 32'd8);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
